mc_controller: RTL
==================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 No parameters.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  opcode from the instruction register, stable from DECODE until the next FETCH completes.
REQ-005 funct  input  6  function field from the instruction register.
REQ-006 zero  input  1  ALU zero flag, sampled combinationally in BRANCH.
REQ-007 memready  input  1  memory completes the current access in this cycle.
REQ-008 memreq  output  1  memory access request.
REQ-009 memwrite  output  1  request is a write.
REQ-010 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-011 irwrite  output  1  instruction register load.
REQ-012 pcen  output  1  PC load.
REQ-013 pcsrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-014 alusrca  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-015 alusrcb  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate shifted left 2.
REQ-016 alucontrol  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-017 signext  output  1  1 = sign-extend, 0 = zero-extend the immediate.
REQ-018 shiftl16  output  1  shift the extended immediate left 16.
REQ-019 regwrite  output  1  register file write enable.
REQ-020 regdst  output  1  destination register: 0 = rt, 1 = rd.
REQ-021 memtoreg  output  1  write-back source: 0 = ALUOut, 1 = memory data.
REQ-022 illegal  output  1  one-cycle pulse when an unsupported op or funct is decoded.
REQ-023 state  output  4  current state encoding (debug).
REQ-024 instret  output  32  count of retired instructions.

Function
REQ-025 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11; encodings 12-15 are unreachable and transition to FETCH.
REQ-026 Default outputs, unless a state below sets them: all enables 0, pcsrc=00, alusrca=0, alusrcb=00, alucontrol=010, signext=0, shiftl16=0, regdst=0, memtoreg=0.
REQ-027 FETCH: memreq=1, iord=0, alusrcb=01, add; irwrite=pcen=memready; stays in FETCH while memready=0, else goes to DECODE.
REQ-028 DECODE: alusrcb=11, signext=1, add; next state by op:
- 100011 (LW) and 101011 (SW) -> MEMADR
- 000000 (R-type) -> EXECUTE
- 000100 (BEQ) and 000101 (BNE) -> BRANCH
- 001000, 001001, 001101, 001111 -> IEXEC
- 000010 (J) -> JUMP
- any other op -> FETCH with illegal=1
REQ-029 Supported R-type funct values: 100000, 100001 (add); 100010, 100011 (sub); 100100 (and); 100101 (or); 101010 (slt). For any other funct, DECODE goes to FETCH with illegal=1.
REQ-030 MEMADR: alusrca=1, alusrcb=10, signext=1, add; goes to MEMRD for LW and MEMWR for SW.
REQ-031 MEMRD: memreq=1, iord=1; waits for memready=1, then goes to MEMWB.
REQ-032 MEMWB: regwrite=1, memtoreg=1, regdst=0; goes to FETCH.
REQ-033 MEMWR: memreq=1, memwrite=1, iord=1; waits for memready=1, then goes to FETCH.
REQ-034 EXECUTE: alusrca=1, alusrcb=00, alucontrol decoded from funct; goes to ALUWB.
REQ-035 ALUWB: regwrite=1, regdst=1; goes to FETCH.
REQ-036 BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01; pcen = zero XOR (op==000101); goes to FETCH.
REQ-037 IEXEC: alusrca=1, alusrcb=10; goes to IWB.
- ADDI/ADDIU: signext=1, add
- ORI: signext=0, or
- LUI: signext=0, shiftl16=1, add
REQ-038 IWB: regwrite=1, regdst=0, memtoreg=0; goes to FETCH.
REQ-039 JUMP: pcsrc=10, pcen=1; goes to FETCH.
REQ-040 All outputs are combinational from state, op, funct, zero and memready; only state and instret are registered.
REQ-041 instret increments by 1 on each transition into FETCH from MEMWB, MEMWR (with memready=1), ALUWB, BRANCH, IWB or JUMP.
REQ-042 instret does not increment on an illegal-decode transition and wraps from 0xFFFFFFFF to 0.
REQ-043 Latency with memready held at 1: R-type 4, LW 5, SW 4, BEQ/BNE 3, immediate ops 4, J 3 cycles.
REQ-044 Each memready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.

Reset
REQ-045 On a clock edge with reset=1: state <= FETCH and instret <= 0, regardless of the current state (including mid-wait in MEMRD or MEMWR).
REQ-046 While reset=1: pcen, irwrite, regwrite, memwrite, memreq and illegal are forced to 0.

Verification
REQ-047 Reset, memready=1, op=000000, funct=100000 -> states 0,1,6,7,0; regwrite=1 and regdst=1 in ALUWB only; instret=1.
REQ-048 LW with memready=0 for 2 FETCH cycles and 1 MEMRD cycle -> 8 cycles total; irwrite pulses exactly once; MEMWB has memtoreg=1.
REQ-049 BNE with zero=0 -> pcen=1, pcsrc=01 in BRANCH; BEQ with zero=0 -> pcen=0; each takes 3 cycles.
REQ-050 op=111111 -> illegal=1 for one cycle in DECODE, next state FETCH, instret unchanged.
REQ-051 Reset asserted in MEMWR with memready=0 -> memwrite=0 immediately; state=0 and instret=0 after the edge.
REQ-052 Preload instret=0xFFFFFFFF via 2^32 retires or force, then a J instruction -> instret=0.

Source files
------------

// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// The controller side is the master: it consumes instruction fields and
// status flags, and drives every control strobe plus its debug outputs.
interface mc_controller_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        memready;

  logic        memreq;
  logic        memwrite;
  logic        iord;
  logic        irwrite;
  logic        pcen;
  logic [1:0]  pcsrc;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic [2:0]  alucontrol;
  logic        signext;
  logic        shiftl16;
  logic        regwrite;
  logic        regdst;
  logic        memtoreg;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] instret;

  modport master (
    input  op, funct, zero, memready,
    output memreq, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
           alucontrol, signext, shiftl16, regwrite, regdst, memtoreg,
           illegal, state, instret
  );

  modport slave (
    output op, funct, zero, memready,
    input  memreq, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
           alucontrol, signext, shiftl16, regwrite, regdst, memtoreg,
           illegal, state, instret
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset controller: one FSM walks each instruction through
// fetch, decode and its execution states, driving the datapath strobes
// combinationally, and counts retired instructions in instret.
module mc_controller (
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IEXEC   = 4'd9,
    S_IWB     = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t      state_reg, state_next;
  logic [31:0] instret_reg;
  logic        retire;
  logic        funct_ok;
  logic [2:0]  funct_alu;

  // Map the R-type function field onto an ALU operation and flag support.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (bus.funct)
      6'b100000, 6'b100001: funct_alu = ALU_ADD;
      6'b100010, 6'b100011: funct_alu = ALU_SUB;
      6'b100100:            funct_alu = ALU_AND;
      6'b100101:            funct_alu = ALU_OR;
      6'b101010:            funct_alu = ALU_SLT;
      default:              funct_ok  = 1'b0;
    endcase
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      instret_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        instret_reg <= instret_reg + 32'd1;
      end
    end
  end

  // Next-state selection and control outputs for the current state.
  always_comb begin
    state_next         = state_reg;
    retire             = 1'b0;
    bus.memreq         = 1'b0;
    bus.memwrite       = 1'b0;
    bus.iord           = 1'b0;
    bus.irwrite        = 1'b0;
    bus.pcen           = 1'b0;
    bus.pcsrc          = 2'b00;
    bus.alusrca        = 1'b0;
    bus.alusrcb        = 2'b00;
    bus.alucontrol     = ALU_ADD;
    bus.signext        = 1'b0;
    bus.shiftl16       = 1'b0;
    bus.regwrite       = 1'b0;
    bus.regdst         = 1'b0;
    bus.memtoreg       = 1'b0;
    bus.illegal        = 1'b0;

    case (state_reg)
      S_FETCH: begin
        bus.memreq  = 1'b1;
        bus.alusrcb = 2'b01;
        bus.irwrite = bus.memready;
        bus.pcen    = bus.memready;
        if (bus.memready) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch target PC + (imm << 2) is precomputed here into ALUOut.
        bus.alusrcb = 2'b11;
        bus.signext = 1'b1;
        case (bus.op)
          OP_LW, OP_SW:   state_next = S_MEMADR;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_J:           state_next = S_JUMP;
          OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: state_next = S_IEXEC;
          OP_RTYPE: begin
            if (funct_ok) begin
              state_next = S_EXECUTE;
            end else begin
              state_next  = S_FETCH;
              bus.illegal = 1'b1;
            end
          end
          default: begin
            state_next  = S_FETCH;
            bus.illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        bus.signext = 1'b1;
        state_next  = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.memreq = 1'b1;
        bus.iord   = 1'b1;
        if (bus.memready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
        state_next   = S_FETCH;
        retire       = 1'b1;
      end
      S_MEMWR: begin
        bus.memreq   = 1'b1;
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
        if (bus.memready) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_EXECUTE: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = funct_alu;
        state_next     = S_ALUWB;
      end
      S_ALUWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
        state_next   = S_FETCH;
        retire       = 1'b1;
      end
      S_BRANCH: begin
        // BNE inverts the sense of the zero flag.
        bus.alusrca    = 1'b1;
        bus.alucontrol = ALU_SUB;
        bus.pcsrc      = 2'b01;
        bus.pcen       = bus.zero ^ (bus.op == OP_BNE);
        state_next     = S_FETCH;
        retire         = 1'b1;
      end
      S_IEXEC: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        case (bus.op)
          OP_ORI: begin
            bus.alucontrol = ALU_OR;
          end
          OP_LUI: begin
            bus.shiftl16 = 1'b1;
          end
          default: begin
            bus.signext = 1'b1;
          end
        endcase
        state_next = S_IWB;
      end
      S_IWB: begin
        bus.regwrite = 1'b1;
        state_next   = S_FETCH;
        retire       = 1'b1;
      end
      S_JUMP: begin
        bus.pcsrc  = 2'b10;
        bus.pcen   = 1'b1;
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase

    // Side-effecting strobes stay quiet while reset is held.
    if (reset) begin
      bus.pcen     = 1'b0;
      bus.irwrite  = 1'b0;
      bus.regwrite = 1'b0;
      bus.memwrite = 1'b0;
      bus.memreq   = 1'b0;
      bus.illegal  = 1'b0;
    end
  end

  assign bus.state   = state_reg;
  assign bus.instret = instret_reg;

endmodule
